sram_arbiter_2p: RTL and testbench

Two-port round-robin arbiter and sequencer that shares one SRAM controller (mem/rw/addr/data_f2s/ready/data_s2f_r command interface) between two independent requesters. It latches a winning request and issues it as a single-cycle command. It then tracks the controller's ready handshake to completion and returns an ack, plus read data, to the winner. A watchdog aborts transactions whose ready handshake stalls.

---
 rtl/sram_arbiter_2p.sv | 135 +++++++++++++
 tb/tb_sram_arbiter_2p.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter_2p.sv
// Two-requester round-robin arbiter that sequences single commands into one SRAM controller
// and returns ack / read data to the winner, with a watchdog on the ready handshake.
module sram_arbiter_2p #(
  parameter int unsigned AW      = 18,
  parameter int unsigned DW      = 16,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          rw0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          rw1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          busy,
  output logic          mem,
  output logic          rw,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_f2s,
  input  logic          ready,
  input  logic [DW-1:0] data_s2f_r
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitLo,
    StWaitHi,
    StDone
  } state_e;

  state_e          state_q;
  logic            last_q;
  logic            winner_q;
  logic [CntW-1:0] cnt_q;

  logic grant_any;
  logic grant_sel;

  // Under contention the port that was not served last wins.
  always_comb begin
    grant_any = req0 | req1;
    grant_sel = (req0 && req1) ? ~last_q : req1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      winner_q <= 1'b0;
      cnt_q    <= '0;
      mem      <= 1'b0;
      rw       <= 1'b1;
      addr     <= '0;
      data_f2s <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rdata    <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mem  <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ready && grant_any) begin
            winner_q <= grant_sel;
            rw       <= grant_sel ? rw1 : rw0;
            addr     <= grant_sel ? addr1 : addr0;
            data_f2s <= grant_sel ? wdata1 : wdata0;
            mem      <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= '0;
          state_q <= StWaitLo;
        end
        StWaitLo: begin
          if (!ready) begin
            cnt_q   <= '0;
            state_q <= StWaitHi;
          end else if (cnt_q == CntMax) begin
            ack0    <= ~winner_q;
            ack1    <= winner_q;
            err     <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWaitHi: begin
          if (ready) begin
            if (rw) begin
              rdata <= data_s2f_r;
            end
            ack0    <= ~winner_q;
            ack1    <= winner_q;
            state_q <= StDone;
          end else if (cnt_q == CntMax) begin
            ack0    <= ~winner_q;
            ack1    <= winner_q;
            err     <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          last_q  <= winner_q;
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter_2p.sv
// Directed bench for sram_arbiter_2p with a small behavioural SRAM controller model.
module tb_sram_arbiter_2p;

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, rw0 = 1'b0, req1 = 1'b0, rw1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, err, busy, mem, rw, ready;
  logic [DW-1:0] rdata, data_f2s;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_s2f_r = '0;

  // Controller model state
  logic          ready_m = 1'b1;
  logic          force_lo = 1'b0;
  int            k_busy = 3;
  int            m_cnt = 0;
  logic [DW-1:0] mem_model [0:255];

  // Monitors
  int   mem_pulses = 0, mem_overlap = 0, ack_both = 0;
  logic mem_prev = 1'b0;

  int checks = 0;
  int errors = 0;

  assign ready = ready_m & ~force_lo;

  always #5 clk = ~clk;

  sram_arbiter_2p #(
    .AW(AW),
    .DW(DW),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req0(req0),
    .rw0(rw0),
    .addr0(addr0),
    .wdata0(wdata0),
    .req1(req1),
    .rw1(rw1),
    .addr1(addr1),
    .wdata1(wdata1),
    .ack0(ack0),
    .ack1(ack1),
    .rdata(rdata),
    .err(err),
    .busy(busy),
    .mem(mem),
    .rw(rw),
    .addr(addr),
    .data_f2s(data_f2s),
    .ready(ready),
    .data_s2f_r(data_s2f_r)
  );

  // Accepts on mem && ready, drops ready for k_busy cycles, then raises it again.
  always @(posedge clk) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) ready_m <= 1'b1;
    end else if (mem && ready) begin
      ready_m <= 1'b0;
      m_cnt   <= k_busy;
      if (rw) data_s2f_r <= mem_model[addr[7:0]];
      else    mem_model[addr[7:0]] <= data_f2s;
    end
  end

  always @(posedge clk) begin
    if (mem) mem_pulses <= mem_pulses + 1;
    if (mem && mem_prev) mem_overlap <= mem_overlap + 1;
    if (ack0 && ack1) ack_both <= ack_both + 1;
    mem_prev <= mem;
  end

  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem, rw, ack0, ack1, err, busy} !== 6'b010000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 010000", {mem, rw, ack0, ack1, err, busy});
    end
    checks++;
    if (addr !== '0 || data_f2s !== '0 || rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data_f2s=%h rdata=%h want all 0", addr, data_f2s, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b mem=%b want 0 0", busy, mem);
    end
  endtask

  task automatic test_single_write();
    int n, p0;
    p0 = mem_pulses;
    k_busy = 3;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 18'h000F0; wdata0 = 16'h00F0;
    @(negedge clk);
    checks++;
    if (mem !== 1'b1 || rw !== 1'b0 || addr !== 18'h000F0 || data_f2s !== 16'h00F0 || busy !== 1'b1)
    begin
      errors++;
      $display("FAIL write_issue: mem=%b rw=%b addr=%h data=%h busy=%b want 1 0 000f0 00f0 1",
               mem, rw, addr, data_f2s, busy);
    end
    wait_ack(n);
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles want 5", n);
    end
    checks++;
    if ({ack0, ack1, err} !== 3'b100) begin
      errors++;
      $display("FAIL write_ack: ack0/ack1/err=%b want 100", {ack0, ack1, err});
    end
    req0 = 1'b0;
    @(negedge clk);
    checks++;
    if (ack0 !== 1'b0 || busy !== 1'b0 || (mem_pulses - p0) !== 1) begin
      errors++;
      $display("FAIL write_end: ack0=%b busy=%b pulses=%0d want 0 0 1", ack0, busy, mem_pulses - p0);
    end
  endtask

  task automatic test_read_back();
    int n;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 18'h000F0; wdata1 = 16'h0000;
    wait_ack(n);
    checks++;
    if (n !== 6 || {ack0, ack1} !== 2'b01 || rdata !== 16'h00F0) begin
      errors++;
      $display("FAIL read_back: n=%0d ack0/ack1=%b rdata=%h want 6 01 00f0", n, {ack0, ack1}, rdata);
    end
    req1 = 1'b0;
    @(negedge clk);
    // A write must leave rdata alone; also seeds address 0x33 for later tests.
    req0 = 1'b1; rw0 = 1'b0; addr0 = 18'h00033; wdata0 = 16'h1234;
    wait_ack(n);
    checks++;
    if (n !== 6 || ack0 !== 1'b1 || rdata !== 16'h00F0) begin
      errors++;
      $display("FAIL rdata_hold: n=%0d ack0=%b rdata=%h want 6 1 00f0", n, ack0, rdata);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_contention();
    int n, p0, ov0, b0;
    logic [1:0] exp;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    p0 = mem_pulses; ov0 = mem_overlap; b0 = ack_both;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 18'h00033; wdata0 = 16'h1234;
    req1 = 1'b1; rw1 = 1'b1; addr1 = 18'h000F0;
    for (int i = 0; i < 6; i++) begin
      wait_ack(n);
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      if (i == 5) begin
        req0 = 1'b0;
        req1 = 1'b0;
      end
      checks++;
      if ({ack1, ack0} !== exp || n !== ((i == 0) ? 6 : 7)) begin
        errors++;
        $display("FAIL contention_%0d: ack1/ack0=%b n=%0d want %b %0d", i, {ack1, ack0}, n, exp,
                 (i == 0) ? 6 : 7);
      end
    end
    @(negedge clk);
    checks++;
    if ((mem_pulses - p0) !== 6 || (mem_overlap - ov0) !== 0 || (ack_both - b0) !== 0) begin
      errors++;
      $display("FAIL contention_counts: pulses=%0d overlap=%0d both=%0d want 6 0 0",
               mem_pulses - p0, mem_overlap - ov0, ack_both - b0);
    end
    checks++;
    if (rdata !== 16'h00F0) begin
      errors++;
      $display("FAIL contention_rdata: got %h want 00f0", rdata);
    end
  endtask

  task automatic test_ready_not_idle();
    int n, bad;
    bad = 0;
    k_busy = 3;
    force_lo = 1'b1;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 18'h00033;
    repeat (10) begin
      @(negedge clk);
      if (mem !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL not_ready_hold: %0d cycles with mem/busy high, want 0", bad);
    end
    force_lo = 1'b0;
    @(negedge clk);
    checks++;
    if (mem !== 1'b1) begin
      errors++;
      $display("FAIL not_ready_issue: mem=%b want 1", mem);
    end
    wait_ack(n);
    checks++;
    if (n !== 5 || ack0 !== 1'b1 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL not_ready_read: n=%0d ack0=%b rdata=%h want 5 1 1234", n, ack0, rdata);
    end
    req0 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int n;
    logic got;
    got = 1'b0;
    k_busy = 20;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 18'h000F0;
    wait_ack(n);
    req0 = 1'b0;
    checks++;
    if (n !== 11 || {ack0, ack1, err} !== 3'b101 || rdata !== 16'h1234) begin
      errors++;
      $display("FAIL timeout_abort: n=%0d ack0/ack1/err=%b rdata=%h want 11 101 1234",
               n, {ack0, ack1, err}, rdata);
    end
    k_busy = 3;
    @(negedge clk);
    checks++;
    if ({ack0, err, busy} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: ack0/err/busy=%b want 000", {ack0, err, busy});
    end
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (got !== 1'b1) begin
      errors++;
      $display("FAIL timeout_ctrl_recover: ready=%b want 1", ready);
    end
  endtask

  task automatic test_reset_mid();
    int n, bad;
    logic got;
    bad = 0;
    got = 1'b0;
    k_busy = 30;
    req0 = 1'b1; rw0 = 1'b0; addr0 = 18'h00040; wdata0 = 16'h5555;
    repeat (5) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_setup: busy=%b ready=%b want 1 0", busy, ready);
    end
    k_busy = 3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({mem, rw, ack0, ack1, err, busy} !== 6'b010000 || addr !== '0 || data_f2s !== '0 ||
        rdata !== '0) begin
      errors++;
      $display("FAIL reset_mid_values: ctrl=%b addr=%h data=%h rdata=%h want 010000 0 0 0",
               {mem, rw, ack0, ack1, err, busy}, addr, data_f2s, rdata);
    end
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        got = 1'b1;
        break;
      end
      if (mem || busy || ack0 || ack1) bad++;
      @(negedge clk);
    end
    checks++;
    if (got !== 1'b1 || bad !== 0) begin
      errors++;
      $display("FAIL reset_mid_wait: ready_seen=%b bad=%0d want 1 0", got, bad);
    end
    @(negedge clk);
    checks++;
    if (mem !== 1'b1 || addr !== 18'h00040 || data_f2s !== 16'h5555) begin
      errors++;
      $display("FAIL reset_mid_issue: mem=%b addr=%h data=%h want 1 00040 5555", mem, addr, data_f2s);
    end
    wait_ack(n);
    req0 = 1'b0;
    checks++;
    if (n !== 5 || {ack0, ack1, err} !== 3'b100) begin
      errors++;
      $display("FAIL reset_mid_ack: n=%0d ack0/ack1/err=%b want 5 100", n, {ack0, ack1, err});
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_ready_not_idle();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
